// File: rtl/nios_fprint_sys_info.sv
// System-identification and timebase slave for the fingerprinting Nios Avalon-MM fabric.
// Read data is captured on the accepting edge and presented on readdata one edge later.
module nios_fprint_sys_info #(
    parameter logic [31:0] SYS_ID     = 32'h55F3_A02D,
    parameter logic [31:0] BUILD_TS   = 32'h0000_0000,
    parameter int unsigned NUM_CORES  = 32'd4,
    parameter int unsigned FPRINT_CH  = 32'd16,
    parameter logic [15:0] HW_VERSION = 16'h0002,
    parameter int unsigned PRESCALE   = 32'd1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    typedef enum logic [2:0] {
        A_SYS_ID    = 3'd0,
        A_TIMESTAMP = 3'd1,
        A_CAPS      = 3'd2,
        A_SCRATCH   = 3'd3,
        A_UPTIME_LO = 3'd4,
        A_UPTIME_HI = 3'd5,
        A_CTRL      = 3'd6
    } addr_e;

    localparam logic [31:0] CAPS_WORD     = {8'(NUM_CORES), 8'(FPRINT_CH), HW_VERSION};
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 32'd1);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    logic        w_wr_accept;
    logic        w_ctrl_wr;
    logic        w_clr;
    logic        w_tick;
    logic        w_snap_load;
    logic [31:0] w_rd_word;

    logic [31:0] r_scratch;
    logic [31:0] r_snapshot;
    logic [31:0] r_rd_data;
    logic        r_rd_pend;
    logic        r_en;
    logic [15:0] r_prescale;
    logic [63:0] r_uptime;

    // A read in the same cycle wins, so the write is simply not accepted.
    assign w_wr_accept = write & ~read;
    assign w_ctrl_wr   = w_wr_accept & (address == A_CTRL) & byteenable[0];
    assign w_clr       = w_ctrl_wr & writedata[1];
    assign w_tick      = r_en & (r_prescale == PRESCALE_LAST);
    assign w_snap_load = read & (address == A_UPTIME_LO);

    // Read-word multiplexer, sampled on the edge that accepts the read.
    always_comb begin
        w_rd_word = 32'h0000_0000;
        case (address)
            A_SYS_ID:    w_rd_word = SYS_ID;
            A_TIMESTAMP: w_rd_word = BUILD_TS;
            A_CAPS:      w_rd_word = CAPS_WORD;
            A_SCRATCH:   w_rd_word = r_scratch;
            A_UPTIME_LO: w_rd_word = r_uptime[31:0];
            A_UPTIME_HI: w_rd_word = r_snapshot;
            A_CTRL:      w_rd_word = {31'h0000_0000, r_en};
            default:     w_rd_word = 32'h0000_0000;
        endcase
    end

    // Timebase: enable, prescaler, 64-bit uptime and the high-word snapshot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en       <= 1'b1;
            r_prescale <= 16'h0000;
            r_uptime   <= 64'h0;
            r_snapshot <= 32'h0000_0000;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= writedata[0];
            end
            if (w_clr) begin
                r_prescale <= 16'h0000;
                r_uptime   <= 64'h0;
                r_snapshot <= 32'h0000_0000;
            end else begin
                if (w_tick) begin
                    r_prescale <= 16'h0000;
                    r_uptime   <= r_uptime + 64'h1;
                end else if (r_en) begin
                    r_prescale <= r_prescale + 16'h0001;
                end
                // Pairing the low-word read with a high-word capture keeps 64-bit reads coherent.
                if (w_snap_load) begin
                    r_snapshot <= r_uptime[63:32];
                end
            end
        end
    end

    // Scratch register with per-byte write lanes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= 32'h0000_0000;
        end else if (w_wr_accept && (address == A_SCRATCH)) begin
            r_scratch <= merge_bytes(r_scratch, writedata, byteenable);
        end
    end

    // Two-stage read return; an asynchronous reset drops any read still in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend     <= 1'b0;
            r_rd_data     <= 32'h0000_0000;
            readdatavalid <= 1'b0;
            readdata      <= 32'h0000_0000;
        end else begin
            r_rd_pend     <= read;
            readdatavalid <= r_rd_pend;
            if (read) begin
                r_rd_data <= w_rd_word;
            end
            if (r_rd_pend) begin
                readdata <= r_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_nios_fprint_sys_info.sv
// Bench for nios_fprint_sys_info: two instances (PRESCALE 4 and 1) on a shared bus,
// checked every cycle against a cycle-count reference model plus directed vectors.
module tb_nios_fprint_sys_info;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rdata0, rdata1;
    logic        rvld0, rvld1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    nios_fprint_sys_info #(.BUILD_TS(32'h6543_21AB), .PRESCALE(4)) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rdata0), .readdatavalid(rvld0)
    );

    nios_fprint_sys_info #(.BUILD_TS(32'h6543_21AB), .PRESCALE(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rdata1), .readdatavalid(rvld1)
    );

    // Reference model: uptime is derived from the number of enabled edges since the last clear.
    logic [31:0] m_scratch;
    logic        m_en;
    logic [63:0] m_cyc [2];
    logic [63:0] m_off [2];
    logic [31:0] m_snap [2];
    logic        m_pend;
    logic [31:0] m_pd [2];
    logic        m_vld;
    logic [31:0] m_rd [2];

    function automatic logic [63:0] m_uptime(input int k);
        logic [63:0] ps;
        ps = (k == 0) ? 64'd4 : 64'd1;
        return (m_cyc[k] / ps) + m_off[k];
    endfunction

    function automatic logic [31:0] m_word(input int k, input logic [2:0] a);
        logic [63:0] up;
        up = m_uptime(k);
        case (a)
            3'd0:    return 32'h55F3_A02D;
            3'd1:    return 32'h6543_21AB;
            3'd2:    return {8'd4, 8'd16, 16'h0002};
            3'd3:    return m_scratch;
            3'd4:    return up[31:0];
            3'd5:    return m_snap[k];
            3'd6:    return {31'd0, m_en};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_hi(input int k);
        logic [63:0] up;
        up = m_uptime(k);
        return up[63:32];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        logic        clr;
        logic [31:0] mask;
        clr  = write && !read && (address == 3'd6) && byteenable[0] && writedata[1];
        mask = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
        if (!reset_n) begin
            m_scratch <= 32'd0;
            m_en      <= 1'b1;
            m_pend    <= 1'b0;
            m_vld     <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_cyc[k]  <= 64'd0;
                m_snap[k] <= 32'd0;
                m_pd[k]   <= 32'd0;
                m_rd[k]   <= 32'd0;
            end
        end else begin
            m_vld  <= m_pend;
            m_pend <= read;
            for (int k = 0; k < 2; k++) begin
                if (m_pend) m_rd[k] <= m_pd[k];
                if (read) m_pd[k] <= m_word(k, address);
                if (clr) begin
                    m_cyc[k]  <= 64'd0;
                    m_snap[k] <= 32'd0;
                end else begin
                    if (m_en) m_cyc[k] <= m_cyc[k] + 64'd1;
                    if (read && address == 3'd4) m_snap[k] <= m_hi(k);
                end
            end
            if (write && !read) begin
                if (address == 3'd3) m_scratch <= (m_scratch & ~mask) | (writedata & mask);
                if (address == 3'd6 && byteenable[0]) m_en <= writedata[0];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare both instances with the model.
    task automatic tick();
        @(negedge clock);
        chk("model_vld0", 64'(rvld0), 64'(m_vld));
        chk("model_vld1", 64'(rvld1), 64'(m_vld));
        chk("model_rdata0", 64'(rdata0), 64'(m_rd[0]));
        chk("model_rdata1", 64'(rdata1), 64'(m_rd[1]));
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d0, output logic [31:0] d1);
        read = 1'b1; write = 1'b0; address = a;
        tick();
        read = 1'b0;
        tick();
        chk("read_vld", 64'(rvld0), 64'd1);
        d0 = rdata0;
        d1 = rdata1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
        tick();
        write = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n  = 1'b0;
        m_off[1] = 64'd0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        logic [31:0] d0, d1, h0, h1;
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 32'h55F3_A02D};
        tbl[1]  = '{1'b1, 1'b0, 3'd1, 32'h0,         4'h0, 32'h6543_21AB};
        tbl[2]  = '{1'b1, 1'b0, 3'd2, 32'h0,         4'h0, 32'h0410_0002};
        tbl[3]  = '{1'b1, 1'b0, 3'd7, 32'h0,         4'h0, 32'h0000_0000};
        tbl[4]  = '{1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 3'd3, 32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[6]  = '{1'b0, 1'b1, 3'd3, 32'h0000_1200, 4'h2, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 3'd3, 32'h0,         4'h0, 32'hDEAD_12EF};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 32'h1111_1111, 4'hF, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 3'd1, 32'h1111_1111, 4'hF, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 32'h1111_1111, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 3'd7, 32'h1111_1111, 4'hF, 32'h0};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 32'h0,         4'h0, 32'h55F3_A02D};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h0,         4'h0, 32'h6543_21AB};
        tbl[14] = '{1'b1, 1'b0, 3'd2, 32'h0,         4'h0, 32'h0410_0002};
        tbl[15] = '{1'b1, 1'b0, 3'd7, 32'h0,         4'h0, 32'h0000_0000};
        tbl[16] = '{1'b0, 1'b1, 3'd6, 32'h0,         4'h0, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 3'd6, 32'h0,         4'h0, 32'h0000_0001};
        tbl[18] = '{1'b1, 1'b1, 3'd3, 32'h0,         4'hF, 32'hDEAD_12EF};
        tbl[19] = '{1'b1, 1'b0, 3'd3, 32'h0,         4'h0, 32'hDEAD_12EF};

        read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0; byteenable = 4'd0;
        m_off[0] = 64'd0;
        m_off[1] = 64'd0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk("reset_rdata", 64'(rdata0), 64'd0);
        chk("reset_vld", 64'(rvld0), 64'd0);
        reset_n = 1'b1;
        tick();

        // Back-to-back vectors; each result is checked two edges after it is driven.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                read = tbl[i].rd; write = tbl[i].wr; address = tbl[i].addr;
                writedata = tbl[i].wdata; byteenable = tbl[i].be;
            end else begin
                read = 1'b0; write = 1'b0;
            end
            tick();
            if (i >= 1) begin
                chk("tbl_vld0", 64'(rvld0), 64'(tbl[i-1].rd));
                chk("tbl_vld1", 64'(rvld1), 64'(tbl[i-1].rd));
                if (tbl[i-1].rd) begin
                    chk("tbl_data0", 64'(rdata0), 64'(tbl[i-1].exp));
                    chk("tbl_data1", 64'(rdata1), 64'(tbl[i-1].exp));
                end
            end
        end

        // Random traffic against the model; clears are kept rare so the counter makes progress.
        for (int i = 0; i < 400; i++) begin
            read       = ($urandom_range(0, 2) == 0);
            write      = ($urandom_range(0, 2) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            if (address == 3'd6) begin
                writedata[0] = ($urandom_range(0, 3) != 0);
                writedata[1] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        read = 1'b0; write = 1'b0;
        tick();

        // Prescaler 4: 40 idle edges give 10 ticks.
        apply_reset();
        repeat (40) tick();
        do_read(3'd4, d0, d1);
        chk("presc_lo0", 64'(d0), 64'd10);
        chk("presc_lo1", 64'(d1), 64'd40);
        do_write(3'd6, 32'h0, 4'h1);
        repeat (100) tick();
        do_read(3'd4, d0, d1);
        chk("disabled_range", 64'((d0 >= 32'd10) && (d0 <= 32'd11)), 64'd1);
        h0 = d0; h1 = d1;
        repeat (20) tick();
        do_read(3'd4, d0, d1);
        chk("disabled_hold0", 64'(d0), 64'(h0));
        chk("disabled_hold1", 64'(d1), 64'(h1));

        // Clear landing on a prescaler wrap edge.
        do_write(3'd6, 32'h1, 4'h1);
        for (int i = 0; i < 8 && (m_cyc[0] % 64'd4) != 64'd3; i++) tick();
        chk("tick_align", m_cyc[0] % 64'd4, 64'd3);
        do_write(3'd6, 32'h3, 4'h1);
        do_read(3'd4, d0, d1);
        chk("clr_lo0", 64'(d0), 64'd0);
        chk("clr_lo1", 64'(d1), 64'd0);
        repeat (10) tick();
        do_read(3'd4, d0, d1);
        chk("resume_lo0", 64'(d0), 64'd3);
        chk("resume_lo1", 64'(d1), 64'd12);
        do_read(3'd6, d0, d1);
        chk("ctrl_rb", 64'(d0), 64'd1);

        // Carry from bit 31 into bit 32 on the PRESCALE=1 instance.
        force dut1.r_uptime = 64'h0000_0000_FFFF_FFFF;
        release dut1.r_uptime;
        m_off[1] = 64'h0000_0000_FFFF_FFFF - m_cyc[1];
        do_read(3'd4, d0, d1);
        do_read(3'd5, h0, h1);
        chk("carry_a", {h1, d1}, 64'h0000_0000_FFFF_FFFF);
        force dut1.r_uptime = 64'h0000_0000_FFFF_FFFF;
        release dut1.r_uptime;
        m_off[1] = 64'h0000_0000_FFFF_FFFF - m_cyc[1];
        tick();
        do_read(3'd4, d0, d1);
        do_read(3'd5, h0, h1);
        chk("carry_b", {h1, d1}, 64'h0000_0001_0000_0000);

        // Reset one cycle after an accepted read: the result never appears.
        read = 1'b1; address = 3'd3;
        tick();
        read = 1'b0;
        reset_n = 1'b0;
        m_off[1] = 64'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_vld0", 64'(rvld0), 64'd0);
            chk("rst_vld1", 64'(rvld1), 64'd0);
        end
        reset_n = 1'b1;
        tick();
        do_read(3'd3, d0, d1);
        chk("rst_scratch", 64'(d0), 64'd0);
        do_read(3'd5, d0, d1);
        chk("rst_snap", 64'(d1), 64'd0);
        do_read(3'd6, d0, d1);
        chk("rst_ctrl", 64'(d0), 64'd1);
        do_read(3'd4, d0, d1);
        chk("rst_uptime0", 64'(d0), 64'd1);
        chk("rst_uptime1", 64'(d1), 64'd7);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_fprint_sys_info.md
Name: nios_fprint_sys_info

Overview:
- Parametrised system-identification and timebase slave on the Avalon-MM control fabric of the fingerprinting Nios system.
- Generalises the fixed two-word ID/timestamp block into an 8-word register map: ID, build timestamp, capability word, a read/write scratch register, and a 64-bit uptime counter with a coherent snapshot read.
- Read latency is fixed at 1 cycle, reported through readdatavalid. Software uses the block for build identification, core/channel discovery and a monotonic timebase.

Parameters:
- SYS_ID, 32'h55F3_A02D: value of word 0.
- BUILD_TS, 32'h0: build timestamp, value of word 1.
- NUM_CORES, 4: placed in CAPS[31:24]; range 1..255.
- FPRINT_CH, 16: fingerprint channel count, placed in CAPS[23:16]; range 0..255.
- HW_VERSION, 16'h0002: placed in CAPS[15:0].
- PRESCALE, 1: clock cycles per uptime tick; range 1..65535.

Ports:
- clock, input, 1: sole clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset; deassertion is synchronised externally.
- address, input, 3: word address.
- read, input, 1: read strobe, one cycle per transfer.
- write, input, 1: write strobe, one cycle per transfer.
- writedata, input, 32: write data.
- byteenable, input, 4: byte lanes for writes.
- readdata, output, 32: registered read data.
- readdatavalid, output, 1: high for exactly one cycle, 1 cycle after an accepted read.

Behaviour:
- Reset values:
  - readdata = 0, readdatavalid = 0.
  - scratch = 0, uptime = 0, snapshot = 0, prescaler = 0.
  - CTRL.en = 1.
- Register map (read value; write effect):
  - 0 SYS_ID: returns SYS_ID; writes ignored.
  - 1 TIMESTAMP: returns BUILD_TS; writes ignored.
  - 2 CAPS: returns {NUM_CORES[7:0], FPRINT_CH[7:0], HW_VERSION}; writes ignored.
  - 3 SCRATCH: read/write. Byte lane i is updated only when byteenable[i] = 1.
  - 4 UPTIME_LO: returns uptime[31:0]. The same read copies uptime[63:32] into snapshot in the same clock edge. Writes ignored.
  - 5 UPTIME_HI: returns snapshot; the live uptime counter is not read. Writes ignored.
  - 6 CTRL: bit0 = en (read/write). bit1 = clr: write-1 pulse, always reads 0. Bits 31:2 read 0. Both bits are gated by byteenable[0].
  - 7: reads 0; writes ignored.
- Read timing:
  - A read accepted at edge N drives readdata and readdatavalid = 1 after edge N+1.
  - Values are sampled at edge N, so UPTIME_LO returns the count before that edge's increment.
  - readdatavalid is held high for 1 cycle only. When no read is accepted, readdata holds its last value.
  - Back-to-back reads on consecutive cycles are supported, one result per cycle.
  - There is no waitrequest; every access completes.
- Read and write in the same cycle: the read is serviced and the write is dropped.
- Write timing: a write accepted at edge N takes effect at edge N; a read issued in cycle N+1 sees the new value.
- Prescaler and uptime counter:
  - While en = 1, the prescaler counts 0..PRESCALE-1 and wraps.
  - uptime increments by 1 on each wrap edge. With PRESCALE = 1 this is every cycle.
  - While en = 0, both the prescaler and uptime hold.
  - uptime is 64-bit and wraps from 2^64-1 to 0 with no flag.
- Clear: writing CTRL with clr = 1 zeroes uptime, prescaler and snapshot at that edge.
  - Clear wins over a simultaneous increment.
  - The en bit in the same write is applied in the same cycle.
- Snapshot coherence:
  - The pair "read word 4, then read word 5" returns a coherent 64-bit value, even across a carry from bit 31 to bit 32.
  - Reading word 5 without a prior word 4 read returns a stale snapshot. This is legal.
- Reset asserted mid-transaction: all state returns to reset values asynchronously. Any pending readdatavalid is cancelled.

Test Plan:
- Identity words: after reset, read addresses 0, 1, 2, 7 with defaults and BUILD_TS = 32'h6543_21AB. Required: 32'h55F3A02D, 32'h654321AB, 32'h04100002 and 0. Each readdatavalid lands exactly 1 cycle after its read.
- Scratch byte lanes:
  - Write 32'hDEADBEEF with byteenable 4'b1111, then 32'h0000_1200 with byteenable 4'b0010. Read back: 32'hDEADBEEF is required first, then 32'hDEAD12EF.
  - Write 32'h1111_1111 to addresses 0, 1, 2, 7; rereading them returns their original values.
- Prescaler and enable:
  - PRESCALE = 4: after reset, 40 idle cycles, then read UPTIME_LO; required value is 10.
  - Write CTRL = 0, wait 100 cycles, read again; the count is unchanged except for at most 1 tick in flight before the write edge.
- Carry coherence:
  - Force uptime to 64'h0000_0000_FFFF_FFFF, with the counter incrementing every cycle.
  - Read word 4 on the cycle before the carry, then word 5; required result is {0, 32'hFFFFFFFF}.
  - Repeat one cycle later; required result is {1, 0}.
- Clear versus increment: write CTRL = 32'h3 on a tick edge. Required: uptime = 0 on the next cycle, counting resumes afterwards, and CTRL reads back 32'h1.
- Read/write collision and reset:
  - Assert read and write together on SCRATCH. Required: the old value is returned and scratch is unchanged.
  - Drop reset_n in the cycle after a read. Required: readdatavalid never asserts, and all registers hold reset values.
